// File: rtl/wb_packer.sv
// wb_packer: collects the engine's 16-bit writeback words and packs BURST_LEN of
// them into one wide output-RAM write with an auto-incrementing address. There are
// two pack slots, so one burst can wait on a stalled DMA while the next one fills.
// Build option: define WB_RELU_EN to store negative CONV results (op_type=1) as zero.
module wb_packer #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 10,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [2:0]              op_type,
  input  logic                    output_en,
  input  logic [15:0]             output_data,
  input  logic                    flush,
  input  logic                    wr_ready,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [16*BURST_LEN-1:0] wr_data,
  output logic [BURST_LEN-1:0]    wr_mask,
  output logic [CNT_W-1:0]        word_count,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int DW    = 16 * BURST_LEN;
  localparam int PTR_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [1:0][DW-1:0]    slot_q, slot_d;        // pack slots A (0) and B (1)
  logic [1:0]            full_q, full_d;        // slot holds a complete burst awaiting transfer
  logic                  fill_sel_q, fill_sel_d; // slot currently receiving words
  logic                  wr_sel_q, wr_sel_d;     // oldest pending slot; equals fill_sel when none pending
  logic [PTR_W-1:0]      ptr_q, ptr_d;          // next lane in the fill slot
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  logic                  pend_any;
  logic                  part_req;
  logic                  flush_done;
  logic                  xfer;
  logic [15:0]           cap_word;
  logic [BURST_LEN-1:0]  part_mask;

`ifdef WB_RELU_EN
  assign cap_word = (op_type == 3'd1 && output_data[15]) ? 16'h0000 : output_data;
`else
  logic unused_op_type;
  assign unused_op_type = ^op_type;
  assign cap_word       = output_data;
`endif

  // Write port handshake: wr_en/wr_addr/wr_data/wr_mask form the valid side and
  // come only from registers; a transfer happens on any cycle with wr_en=1 and
  // wr_ready=1, and while wr_en=1 with wr_ready=0 the payload does not change.
  assign pend_any   = |full_q;
  assign part_req   = (state_q == S_FLUSH) && !pend_any && (ptr_q != '0);
  assign flush_done = (state_q == S_FLUSH) && !pend_any && (ptr_q == '0);
  assign wr_en      = full_q[wr_sel_q] | part_req;
  assign xfer       = wr_en & wr_ready;
  assign wr_addr    = addr_q;
  assign wr_data    = wr_en ? slot_q[wr_sel_q] : '0;
  assign wr_mask    = full_q[wr_sel_q] ? '1 : (part_req ? part_mask : '0);
  assign word_count = cnt_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = flush_done;
  assign overflow   = ovf_q;

  // Lane-valid mask for a partial burst: lanes below the fill pointer.
  always_comb begin
    part_mask = '0;
    for (int i = 0; i < BURST_LEN; i++) part_mask[i] = (i < int'(ptr_q));
  end

  // Next-state logic: layer start, write retirement, word capture and flush sequencing.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    full_d     = full_q;
    fill_sel_d = fill_sel_q;
    wr_sel_d   = wr_sel_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          slot_d     = '0;
          full_d     = '0;
          fill_sel_d = 1'b0;
          wr_sel_d   = 1'b0;
          ptr_d      = '0;
          addr_d     = base_addr;
          cnt_d      = '0;
          ovf_d      = 1'b0;
        end
      end
      S_RUN, S_FLUSH: begin
        // A retired slot is zeroed so a later partial burst shows zeros in unused lanes.
        if (xfer) begin
          slot_d[wr_sel_q] = '0;
          addr_d           = addr_q + ADDR_W'(1);
          if (part_req) begin
            ptr_d = '0;
          end else begin
            full_d[wr_sel_q] = 1'b0;
            wr_sel_d         = ~wr_sel_q;
          end
        end
        if (state_q == S_RUN) begin
          if (output_en) begin
            if (full_q[fill_sel_q]) begin
              ovf_d = 1'b1;
            end else begin
              slot_d[fill_sel_q][int'(ptr_q)*16 +: 16] = cap_word;
              cnt_d = cnt_q + CNT_W'(1);
              if (ptr_q == PTR_LAST) begin
                ptr_d              = '0;
                full_d[fill_sel_q] = 1'b1;
                fill_sel_d         = ~fill_sel_q;
              end else begin
                ptr_d = ptr_q + PTR_W'(1);
              end
            end
          end
          if (flush) state_d = S_FLUSH;
        end else if (flush_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; a pending write is abandoned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      full_q     <= '0;
      fill_sel_q <= 1'b0;
      wr_sel_q   <= 1'b0;
      ptr_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      full_q     <= full_d;
      fill_sel_q <= fill_sel_d;
      wr_sel_q   <= wr_sel_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_wb_packer.sv
// tb_wb_packer: table-driven and directed sequences plus randomized traffic for
// wb_packer, checked every cycle against a queue-based model of the packer.
module tb_wb_packer;
  localparam int BL = 8;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam int DW = 16 * BL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [2:0]    op_type = 3'd2;
  logic          output_en = 1'b0;
  logic [15:0]   output_data = '0;
  logic          flush = 1'b0;
  logic          wr_ready = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [BL-1:0] wr_mask;
  logic [CW-1:0] word_count;
  logic          busy, done, overflow;

  wb_packer #(.BURST_LEN(BL), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .op_type(op_type),
    .output_en(output_en), .output_data(output_data), .flush(flush), .wr_ready(wr_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .word_count(word_count), .busy(busy), .done(done), .overflow(overflow)
  );

  // clock
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Layer state: 0 idle, 1 collecting, 2 flushing. Words being collected sit in
  // m_fill; completed bursts wait in m_pend (two slots total, so at most two).
  int            m_state = 0;
  logic [15:0]   m_fill[$];
  logic [DW-1:0] m_pend[$];
  logic [AW-1:0] m_addr = '0;
  logic [CW-1:0] m_cnt = '0;
  logic          m_ovf = 1'b0;

  // scoreboard: expected write addresses vs addresses seen on transfers
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_addr[$];

  function automatic logic [15:0] relu(input logic [15:0] w, input logic [2:0] op);
    logic [15:0] r;
    r = w;
`ifdef WB_RELU_EN
    if (op == 3'd1 && w[15]) r = 16'h0000;
`endif
    if (op == 3'd0) r = w;
    return r;
  endfunction

  function automatic logic [DW-1:0] fill_data();
    logic [DW-1:0] d;
    d = '0;
    foreach (m_fill[i]) d[i*16 +: 16] = m_fill[i];
    return d;
  endfunction

  function automatic logic m_wr_en();
    return (m_pend.size() > 0) || (m_state == 2 && m_fill.size() > 0);
  endfunction

  function automatic logic m_done();
    return (m_state == 2) && (m_pend.size() == 0) && (m_fill.size() == 0);
  endfunction

  task automatic model_update(input logic st, input logic [AW-1:0] base, input logic oen,
                              input logic [15:0] d, input logic fl, input logic rdy,
                              input logic [2:0] op, input logic rstv);
    logic en, dn, room;
    if (!rstv) begin
      m_state = 0; m_fill.delete(); m_pend.delete();
      m_addr = '0; m_cnt = '0; m_ovf = 1'b0;
      return;
    end
    en = m_wr_en();
    dn = m_done();
    case (m_state)
      0: if (st) begin
        m_state = 1; m_addr = base; m_cnt = '0; m_ovf = 1'b0;
        m_fill.delete(); m_pend.delete();
      end
      1: begin
        room = (m_pend.size() < 2);
        if (en && rdy) begin
          void'(m_pend.pop_front());
          m_addr = m_addr + 1'b1;
        end
        if (oen) begin
          if (!room) m_ovf = 1'b1;
          else begin
            m_fill.push_back(relu(d, op));
            m_cnt = m_cnt + 1'b1;
            if (m_fill.size() == BL) begin
              m_pend.push_back(fill_data());
              m_fill.delete();
            end
          end
        end
        if (fl) m_state = 2;
      end
      default: begin
        if (en && rdy) begin
          if (m_pend.size() > 0) void'(m_pend.pop_front());
          else m_fill.delete();
          m_addr = m_addr + 1'b1;
        end else if (dn) begin
          m_state = 0;
        end
      end
    endcase
  endtask

  task automatic compare_model();
    logic          e_en;
    logic [DW-1:0] e_data;
    logic [BL-1:0] e_mask;
    e_en = m_wr_en();
    chk("wr_en", wr_en, e_en);
    chk("busy", busy, m_state != 0);
    chk("done", done, m_done());
    chk("overflow", overflow, m_ovf);
    chk("word_count", word_count, m_cnt);
    if (e_en) begin
      if (m_pend.size() > 0) begin
        e_data = m_pend[0];
        e_mask = '1;
      end else begin
        e_data = fill_data();
        e_mask = BL'((1 << m_fill.size()) - 1);
      end
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, e_data);
      chk("wr_mask", wr_mask, e_mask);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic st, input logic [AW-1:0] base, input logic oen,
                      input logic [15:0] d, input logic fl, input logic rdy,
                      input logic [2:0] op, input logic rstv);
    @(negedge clk);
    rst = rstv; start = st; base_addr = base; output_en = oen; output_data = d;
    flush = fl; wr_ready = rdy; op_type = op;
    #1;
    if (rst && wr_en && wr_ready) got_addr.push_back(wr_addr);
    @(posedge clk);
    model_update(st, base, oen, d, fl, rdy, op, rstv);
    #1;
    compare_model();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 16'h0, 1'b0, rdy, 3'd2, 1'b1);
  endtask

  task automatic flush_and_wait(input string name);
    logic seen;
    seen = 1'b0;
    step(1'b0, '0, 1'b0, 16'h0, 1'b1, 1'b1, 3'd2, 1'b1);
    for (int i = 0; i < 30 && !seen; i++) begin
      if (done) seen = 1'b1;
      else idle(1, 1'b1);
    end
    chk(name, seen, 1'b1);
    idle(1, 1'b1);
  endtask

  task automatic check_addrs(input string name);
    chk({name, "_count"}, got_addr.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", name, i), (i < got_addr.size()) ? got_addr[i] : 'x, exp_q[i]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          st;
    logic [AW-1:0] base;
    logic          oen;
    logic [15:0]   d;
    logic          fl;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic [BL-1:0] e_mask;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_cnt;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [DW-1:0] basic, part;
    logic [15:0]   w;
    logic          st, oen, fl, rdy, rv;
    logic [AW-1:0] b;
    logic [2:0]    op;

    // reset
    idle(0, 1'b0);
    step(1'b0, '0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd2, 1'b0);
    step(1'b0, '0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd2, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, '0);
    chk("rst_wr_data", wr_data, '0);
    chk("rst_wr_mask", wr_mask, '0);
    chk("rst_count", word_count, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);

    // table: basic pack at 0x040, then a 3-word partial flush
    basic = '0;
    for (int i = 0; i < BL; i++) basic[i*16 +: 16] = 16'h3C00 + 16'(i);
    part = '0;
    part[15:0] = 16'h1111; part[31:16] = 16'h2222; part[47:32] = 16'h3333;
    tbl[0] = '{1'b1, 10'h040, 1'b0, 16'h0, 1'b0, 1'b0, 10'h0, 8'h00, '0, 16'd0, 1'b1, 1'b0};
    for (int k = 1; k <= 8; k++)
      tbl[k] = '{1'b0, 10'h0, 1'b1, 16'h3C00 + 16'(k - 1), 1'b0, (k == 8), 10'h040, 8'hFF,
                 basic, 16'(k), 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 10'h0, 1'b0, 16'h0, 1'b0, 1'b0, 10'h0, 8'h00, '0, 16'd8, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 10'h0, 1'b1, 16'h1111, 1'b0, 1'b0, 10'h0, 8'h00, '0, 16'd9, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 10'h0, 1'b1, 16'h2222, 1'b0, 1'b0, 10'h0, 8'h00, '0, 16'd10, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 10'h0, 1'b1, 16'h3333, 1'b0, 1'b0, 10'h0, 8'h00, '0, 16'd11, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 10'h0, 1'b0, 16'h0, 1'b1, 1'b1, 10'h041, 8'h07, part, 16'd11, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 10'h0, 1'b0, 16'h0, 1'b0, 1'b0, 10'h0, 8'h00, '0, 16'd11, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 10'h0, 1'b0, 16'h0, 1'b0, 1'b0, 10'h0, 8'h00, '0, 16'd11, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].st, tbl[i].base, tbl[i].oen, tbl[i].d, tbl[i].fl, 1'b1, 3'd2, 1'b1);
      chk($sformatf("t%0d_wr_en", i), wr_en, tbl[i].e_en);
      chk($sformatf("t%0d_count", i), word_count, tbl[i].e_cnt);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("t%0d_done", i), done, tbl[i].e_done);
      if (tbl[i].e_en) begin
        chk($sformatf("t%0d_addr", i), wr_addr, tbl[i].e_addr);
        chk($sformatf("t%0d_mask", i), wr_mask, tbl[i].e_mask);
        chk($sformatf("t%0d_data", i), wr_data, tbl[i].e_data);
      end
    end

    // back-to-back bursts with a stall on the first write
    got_addr.delete();
    step(1'b1, 10'h100, 1'b0, 16'h0, 1'b0, 1'b1, 3'd2, 1'b1);
    for (int i = 0; i < 24; i++)
      step(1'b0, '0, 1'b1, 16'($urandom), 1'b0, !(i >= 8 && i <= 14), 3'd2, 1'b1);
    idle(6, 1'b1);
    exp_q = '{10'h100, 10'h101, 10'h102};
    check_addrs("stall_addr");
    chk("stall_overflow", overflow, 1'b0);
    chk("stall_count", word_count, 16'd24);
    flush_and_wait("stall_done");

    // overflow with the DMA permanently stalled
    step(1'b1, 10'h000, 1'b0, 16'h0, 1'b0, 1'b0, 3'd2, 1'b1);
    for (int i = 0; i < 17; i++) begin
      w = (i == 0) ? 16'hA5A5 : 16'($urandom);
      step(1'b0, '0, 1'b1, w, 1'b0, 1'b0, 3'd2, 1'b1);
      if (i == 15) chk("ovf_before", overflow, 1'b0);
    end
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_count", word_count, 16'd16);
    chk("ovf_held_en", wr_en, 1'b1);
    chk("ovf_held_addr", wr_addr, 10'h000);
    chk("ovf_held_lane0", wr_data[15:0], 16'hA5A5);
    idle(4, 1'b1);
    chk("ovf_sticky", overflow, 1'b1);
    flush_and_wait("ovf_done");

    // address wrap, then an empty flush
    got_addr.delete();
    step(1'b1, 10'h3FF, 1'b0, 16'h0, 1'b0, 1'b1, 3'd2, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 16'($urandom), 1'b0, 1'b1, 3'd2, 1'b1);
    idle(3, 1'b1);
    exp_q = '{10'h3FF, 10'h000};
    check_addrs("wrap_addr");
    step(1'b0, '0, 1'b0, 16'h0, 1'b1, 1'b1, 3'd2, 1'b1);
    chk("empty_flush_done", done, 1'b1);
    chk("empty_flush_no_wr", wr_en, 1'b0);
    idle(1, 1'b1);
    chk("empty_flush_idle", busy, 1'b0);

    // ReLU option on CONV words, then reset while a write is pending
    step(1'b1, 10'h020, 1'b0, 16'h0, 1'b0, 1'b0, 3'd1, 1'b1);
    step(1'b0, '0, 1'b1, 16'hBC00, 1'b0, 1'b0, 3'd1, 1'b1);
    step(1'b0, '0, 1'b1, 16'h3C00, 1'b0, 1'b0, 3'd1, 1'b1);
    step(1'b0, '0, 1'b1, 16'h8001, 1'b0, 1'b0, 3'd2, 1'b1);
    for (int i = 3; i < BL; i++) step(1'b0, '0, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 3'd2, 1'b1);
    chk("relu_en", wr_en, 1'b1);
`ifdef WB_RELU_EN
    chk("relu_lane0", wr_data[15:0], 16'h0000);
`else
    chk("relu_lane0", wr_data[15:0], 16'hBC00);
`endif
    chk("relu_lane1", wr_data[31:16], 16'h3C00);
    chk("relu_lane2", wr_data[47:32], 16'h8001);
    step(1'b0, '0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd2, 1'b0);
    chk("mid_rst_wr_en", wr_en, 1'b0);
    chk("mid_rst_addr", wr_addr, '0);
    chk("mid_rst_data", wr_data, '0);
    chk("mid_rst_mask", wr_mask, '0);
    chk("mid_rst_count", word_count, '0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_overflow", overflow, 1'b0);
    idle(2, 1'b1);
    chk("mid_rst_no_retry", wr_en, 1'b0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      st  = ($urandom_range(0, 9) == 0);
      b   = AW'($urandom);
      oen = ($urandom_range(0, 9) < 7);
      w   = 16'($urandom);
      fl  = ($urandom_range(0, 79) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      op  = 3'($urandom_range(1, 3));
      rv  = ($urandom_range(0, 999) != 0);
      step(st, b, oen, w, fl, rdy, op, rv);
    end
    idle(4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
